// File: rtl/rx_uart.sv
// rtl/rx_uart.sv - 8N1 UART receiver with mid-bit sampling, valid/ready output and frame/overrun flags.
// Optional 2-of-3 majority bit sampling is enabled by defining RX_GLITCH_FILTER_EN.
module rx_uart #(
  parameter int SYSTEM_CLK = 100_000_000,
  parameter int BAUDRATE   = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       ready,
  output logic       valid,
  output logic [7:0] rx_data,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CPS   = SYSTEM_CLK / BAUDRATE;
  localparam int HALF  = CPS / 2;
  localparam int CNT_W = $clog2(CPS) + 1;

  localparam logic [CNT_W-1:0] CPS_M1  = CNT_W'(CPS - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             deliver;
  logic             rx_s, fall, cnt_zero, sample;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rx_s     = sync2_q;
  assign fall     = prev_q & ~rx_s;
  assign cnt_zero = (cnt_q == '0);

`ifdef RX_GLITCH_FILTER_EN
  // hist_q holds the synchronized line from one and two cycles ago (counter 1 and 2 at the sample point)
  logic [1:0] hist_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (fall) state_d = START;
      START:     if (cnt_zero) state_d = sample ? IDLE : DATA;
      DATA:      if (cnt_zero && bit_idx_q == 3'd7) state_d = STOP;
      STOP:      if (cnt_zero) state_d = sample ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    deliver     = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) cnt_d = HALF_M1;
      end
      START: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (!sample) begin
          cnt_d     = CPS_M1;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          shift_d   = {sample, shift_q[7:1]};
          cnt_d     = CPS_M1;
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (sample) begin
          deliver = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: ;
    endcase

    // A byte arriving while the previous one is still held is dropped, unless that one leaves this cycle
    valid_d   = valid_q;
    rx_data_d = rx_data_q;
    overrun_d = 1'b0;
    if (deliver) begin
      if (!valid_q || ready) begin
        valid_d   = 1'b1;
        rx_data_d = shift_q;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      valid_q     <= 1'b0;
      rx_data_q   <= 8'h00;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      valid_q     <= valid_d;
      rx_data_q   <= rx_data_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign valid     = valid_q;
  assign rx_data   = rx_data_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
